// File: rtl/pid_pkg.sv
// Purpose: shared types and defaults for the PWM drive stage of the PID loop.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package pid_pkg;

   // Default PWM counter width; period is 2**CNT_W clock cycles
   localparam int CNT_W_DEF = 10;

   // Width of the signed PID controller output feeding the drive
   localparam int UK_W = 17;

   // Drive sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } pwm_state_t;

endpackage : pid_pkg

// File: rtl/sat_clip.sv
// Purpose: clip a signed controller output into the unsigned duty range [0, 2**CNT_W-1].
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid whenever the input is.
module sat_clip
   import pid_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)
(
   input  logic signed [UK_W-1:0] i_uk0,
   output logic [CNT_W-1:0]       o_duty,
   output logic                   o_sat_hi,
   output logic                   o_sat_lo
);

   localparam int DUTY_MAX = (1 << CNT_W) - 1;

   // Sign-extend to 32 bits so the range test is a plain signed integer compare
   logic signed [31:0] w_uk0_ext;
   assign w_uk0_ext = {{(32 - UK_W){i_uk0[UK_W-1]}}, i_uk0};

   // Negative inputs clamp to zero, oversize inputs clamp to full scale
   always_comb begin
      o_duty   = i_uk0[CNT_W-1:0];
      o_sat_hi = 1'b0;
      o_sat_lo = 1'b0;
      if (w_uk0_ext < 0) begin
         o_duty   = '0;
         o_sat_lo = 1'b1;
      end else if (w_uk0_ext > DUTY_MAX) begin
         o_duty   = '1;
         o_sat_hi = 1'b1;
      end
   end

endmodule : sat_clip

// File: rtl/pwm_drive.sv
// Purpose: PWM generator driven by a saturated PID output, with glitch-free per-period duty reload.
// Latency: pwm is registered, one cycle behind the counter compare; duty loads on the wrap edge.
// Backpressure: none; a stop request lets the current period finish before returning to idle.
module pwm_drive
   import pid_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic signed [UK_W-1:0] uk0,
   output logic                   pwm,
   output logic [CNT_W-1:0]       duty,
   output logic                   sat_hi,
   output logic                   sat_lo,
   output logic                   period_start,
   output logic                   busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   pwm_state_t       r_state;
   pwm_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_duty;
   logic             r_sat_hi;
   logic             r_sat_lo;
   logic             r_pwm;

   logic [CNT_W-1:0] w_clip_duty;
   logic             w_clip_hi;
   logic             w_clip_lo;
   logic             w_active;
   logic             w_wrap;
   logic             w_load;

   sat_clip #(
      .CNT_W (CNT_W)
   ) u_sat_clip (
      .i_uk0    (uk0),
      .o_duty   (w_clip_duty),
      .o_sat_hi (w_clip_hi),
      .o_sat_lo (w_clip_lo)
   );

   // Counter runs in RUN and STOP; the last count of a period is the wrap point
   assign w_active = (r_state != ST_IDLE);
   assign w_wrap   = w_active && (r_cnt == CNT_MAX);

   // Duty is captured when starting from idle, and at every wrap taken while in RUN
   // (including the wrap on which a stop request is seen); never while stopping
   assign w_load = ((r_state == ST_IDLE) && en) || ((r_state == ST_RUN) && w_wrap);

   // Sequencer: a stop request lets the period finish; re-asserting en resumes in place
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (en) w_state_nxt = ST_RUN;
         ST_RUN:  if (!en) w_state_nxt = ST_STOP;
         ST_STOP: begin
            if (en) begin
               w_state_nxt = ST_RUN;
            end else if (w_wrap) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Period counter: held at zero in idle, free-running modulo 2**CNT_W otherwise,
   // so the first active cycle after leaving idle is count zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!w_active) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Applied duty and saturation flags; they hold their value between loads, including in idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_duty   <= '0;
         r_sat_hi <= 1'b0;
         r_sat_lo <= 1'b0;
      end else if (w_load) begin
         r_duty   <= w_clip_duty;
         r_sat_hi <= w_clip_hi;
         r_sat_lo <= w_clip_lo;
      end
   end

   // Registered compare keeps the output free of combinational glitches; full-scale duty
   // still leaves the last count of each period low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm <= 1'b0;
      end else begin
         r_pwm <= w_active && (r_cnt < r_duty);
      end
   end

   assign pwm          = r_pwm;
   assign duty         = r_duty;
   assign sat_hi       = r_sat_hi;
   assign sat_lo       = r_sat_lo;
   assign period_start = w_active && (r_cnt == '0);
   assign busy         = w_active;

endmodule : pwm_drive

// File: doc/pwm_drive.md
PWM_DRIVE -- requirements
Module: pwm_drive

Interface
REQ-001 SHALL have parameter CNT_W, default 10, PWM counter width; period = 2**CNT_W cycles.
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port en  input  1  run request; high starts or continues PWM, low requests stop.
REQ-005 SHALL have port uk0  input  17 signed  PID controller output, two's complement.
REQ-006 SHALL have port pwm  output  1  PWM drive signal.
REQ-007 SHALL have port duty  output  CNT_W  currently applied duty value.
REQ-008 SHALL have port sat_hi  output  1  last loaded uk0 was clipped to maximum.
REQ-009 SHALL have port sat_lo  output  1  last loaded uk0 was clipped to zero.
REQ-010 SHALL have port period_start  output  1  one-cycle pulse on the first cycle of each running period.
REQ-011 SHALL have port busy  output  1  high in RUN and STOP states.

Function
REQ-012 SHALL implement states IDLE, RUN and STOP.
REQ-013 In IDLE, cnt SHALL be held at 0 and pwm SHALL be 0.
REQ-014 IDLE SHALL go to RUN when en=1, loading duty from uk0 on that same edge.
REQ-015 In RUN and STOP, cnt SHALL increment each cycle and wrap from 2**CNT_W-1 to 0.
REQ-016 Duty loading SHALL use saturation:
- uk0<0 gives duty=0, sat_lo=1, sat_hi=0.
- uk0>2**CNT_W-1 gives duty=2**CNT_W-1, sat_hi=1, sat_lo=0.
- Otherwise duty=uk0[CNT_W-1:0] and both flags are 0.
REQ-017 In RUN, duty, sat_hi and sat_lo SHALL reload only on the edge where cnt wraps to 0, so the new duty first applies on the cnt==0 cycle; mid-period uk0 changes SHALL be ignored.
REQ-018 pwm SHALL be registered and equal 1 in the cycle after (state!=IDLE and cnt<duty), giving one cycle of latency; duty=0 SHALL give a constant 0.
REQ-019 duty=2**CNT_W-1 SHALL give pwm low for exactly 1 cycle per period.
REQ-020 period_start SHALL pulse for one cycle when cnt==0 in RUN or STOP, including the first period after leaving IDLE.
REQ-021 When en falls in RUN, the state SHALL go to STOP; STOP SHALL complete the current period without reloading duty, then go to IDLE on wrap.
REQ-022 If en returns high in STOP, the state SHALL go to RUN immediately without a counter discontinuity; the next wrap reloads duty.
REQ-023 If wrap and the en fall occur on the same edge, the state SHALL go to STOP and duty SHALL reload (it is a RUN wrap).
REQ-024 In IDLE, duty and the sat flags SHALL hold their last values.

Reset
REQ-025 When rst_n=0, outputs SHALL be forced within the same cycle (asynchronous) to: state=IDLE, cnt=0, pwm=0, duty=0, sat_hi=0, sat_lo=0, period_start=0, busy=0.
REQ-026 Reset asserted mid-period SHALL abort immediately; after release, operation SHALL restart from IDLE.
REQ-027 Reset SHALL be released synchronously externally; the block SHALL NOT contain a reset synchroniser.

Structure
REQ-028 Shared package pid_pkg SHALL hold the state enum type and the default CNT_W constant.
REQ-029 Saturation SHALL be a combinational sub-module sat_clip (17-bit signed in, CNT_W out, plus hi/lo flags), instantiated once.
REQ-030 The counter, FSM and output registers SHALL reside in pwm_drive.

Verification
REQ-031 Reset then en=1 with uk0=256, CNT_W=10 -> pwm high 256 of every 1024 cycles, period_start every 1024 cycles, sat flags 0.
REQ-032 uk0=-5 then uk0=5000 -> after the respective wraps duty=0 with sat_lo=1 and pwm constantly 0, then duty=1023 with sat_hi=1 and pwm low 1 cycle per period.
REQ-033 uk0 changed 100->700 at cnt=50 -> the current period keeps 100 high cycles; the next period has 700.
REQ-034 en dropped at cnt=300 -> busy stays 1 until wrap, the period completes, then IDLE with pwm=0 and cnt=0; en re-raised at cnt=600 in STOP -> RUN with no period_start glitch.
REQ-035 rst_n pulsed low at cnt=500 with pwm=1 -> pwm=0, duty=0 and busy=0 within the same cycle, asynchronously.
REQ-036 Random uk0 over 200 periods -> the per-period high count equals the clipped value latched at each wrap.
